program_yukleyici: RTL and testbench

Upstream instruction-supply stage for the single-cycle `islemci` core. Receives a program as a byte stream with a valid/ready handshake and assembles little-endian 32-bit words into an internal instruction RAM. While loading, it holds the core in reset. Once loaded, it releases the core and serves `buyruk` combinationally from the core's `ps`.

---
 rtl/program_yukleyici_pkg.sv | 18 +
 rtl/program_yukleyici_if.sv | 13 +
 rtl/program_yukleyici_buyruk_ram.sv | 26 ++
 rtl/program_yukleyici.sv | 138 +++++++++++++
 tb/tb_program_yukleyici.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/program_yukleyici_pkg.sv
// Shared types and constants for the program loader: loader states,
// the filler instruction and the byte-lane width of the input stream.
package program_yukleyici_pkg;

  typedef enum logic [2:0] {
    BASLIK0 = 3'd0,
    BASLIK1 = 3'd1,
    VERI    = 3'd2,
    CALIS   = 3'd3,
    HATA    = 3'd4
  } durum_t;

  // addi x0,x0,0 -- harmless instruction served whenever no valid word exists
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int BAYT_W = 8;

endpackage

// File: rtl/program_yukleyici_if.sv
// Byte-stream handshake between a program source and the loader.
// The source drives data and valid, the loader answers with ready.
interface program_yukleyici_if;
  import program_yukleyici_pkg::*;

  logic              bayt_gecerli;
  logic [BAYT_W-1:0] bayt;
  logic              bayt_hazir;

  modport master (output bayt_gecerli, output bayt, input  bayt_hazir);
  modport slave  (input  bayt_gecerli, input  bayt, output bayt_hazir);

endinterface

// File: rtl/program_yukleyici_buyruk_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the loader.
module buyruk_ram #(
  parameter int DERINLIK = 256,
  localparam int ADR_W   = $clog2(DERINLIK)
) (
  input  logic             saat,
  input  logic             yaz_en,
  input  logic [ADR_W-1:0] yaz_adres,
  input  logic [31:0]      yaz_veri,
  input  logic [ADR_W-1:0] oku_adres,
  output logic [31:0]      oku_veri
);

  logic [31:0] bellek [DERINLIK];

  // Store a completed word on the edge that accepts its last byte
  always_ff @(posedge saat) begin
    if (yaz_en) begin
      bellek[yaz_adres] <= yaz_veri;
    end
  end

  assign oku_veri = bellek[oku_adres];

endmodule

// File: rtl/program_yukleyici.sv
// Program loader: takes a length header and little-endian instruction bytes,
// fills the instruction RAM while holding the core in reset, then releases
// the core and serves instructions combinationally from its program counter.
module program_yukleyici
  import program_yukleyici_pkg::*;
#(
  parameter int DERINLIK = 256,
  localparam int ADR_W   = $clog2(DERINLIK)
) (
  input  logic                saat,
  input  logic                reset_n,
  program_yukleyici_if.slave  bayt_if,
  input  logic                yeniden,
  input  logic [31:0]         ps,
  output logic [31:0]         buyruk,
  output logic                islemci_reset,
  output logic                calisiyor,
  output logic                hata
);

  durum_t           durum, durum_s;
  logic [15:0]      n, n_s;
  logic [ADR_W-1:0] adres, adres_s;
  logic [1:0]       k, k_s;
  logic [23:0]      kelime, kelime_s;
  logic             yaz_en;
  logic             aktarim;
  logic [15:0]      yeni_n;
  logic [31:0]      yaz_veri;
  logic [31:0]      ram_veri;
  logic             adreste_gecerli;

  assign bayt_if.bayt_hazir = (durum == BASLIK0) || (durum == BASLIK1) || (durum == VERI);
  assign aktarim            = bayt_if.bayt_gecerli && bayt_if.bayt_hazir;
  assign yeni_n             = {bayt_if.bayt, n[7:0]};
  assign yaz_veri           = {bayt_if.bayt, kelime};
  assign calisiyor          = (durum == CALIS);
  assign hata               = (durum == HATA);

  // State register plus the header, address, byte-index and assembly registers
  always_ff @(posedge saat or negedge reset_n) begin
    if (!reset_n) begin
      durum  <= BASLIK0;
      n      <= '0;
      adres  <= '0;
      k      <= '0;
      kelime <= '0;
    end else begin
      durum  <= durum_s;
      n      <= n_s;
      adres  <= adres_s;
      k      <= k_s;
      kelime <= kelime_s;
    end
  end

  // Next-state logic: header decode, byte assembly, word write and reload
  always_comb begin
    durum_s  = durum;
    n_s      = n;
    adres_s  = adres;
    k_s      = k;
    kelime_s = kelime;
    yaz_en   = 1'b0;
    case (durum)
      BASLIK0: begin
        if (aktarim) begin
          n_s     = {n[15:8], bayt_if.bayt};
          durum_s = BASLIK1;
        end
      end
      BASLIK1: begin
        if (aktarim) begin
          n_s = yeni_n;
          if (yeni_n == 16'd0) begin
            durum_s = CALIS;
          end else if (32'(yeni_n) > 32'(DERINLIK)) begin
            durum_s = HATA;
          end else begin
            durum_s = VERI;
            adres_s = '0;
            k_s     = '0;
          end
        end
      end
      VERI: begin
        if (aktarim) begin
          case (k)
            2'd0: kelime_s[7:0]   = bayt_if.bayt;
            2'd1: kelime_s[15:8]  = bayt_if.bayt;
            2'd2: kelime_s[23:16] = bayt_if.bayt;
            default: begin
              yaz_en  = 1'b1;
              adres_s = adres + 1'b1;
              if (32'(adres) == 32'(n) - 32'd1) begin
                durum_s = CALIS;
              end
            end
          endcase
          k_s = k + 2'd1;
        end
      end
      CALIS: begin
        if (yeniden) begin
          durum_s = BASLIK0;
        end
      end
      HATA: begin
        durum_s = HATA;
      end
      default: begin
        durum_s = BASLIK0;
      end
    endcase
  end

  // Core reset is low exactly while the loader sits in CALIS
  always_ff @(posedge saat or negedge reset_n) begin
    if (!reset_n) begin
      islemci_reset <= 1'b1;
    end else begin
      islemci_reset <= (durum_s != CALIS);
    end
  end

  buyruk_ram #(.DERINLIK(DERINLIK)) u_buyruk_ram (
    .saat      (saat),
    .yaz_en    (yaz_en),
    .yaz_adres (adres),
    .yaz_veri  (yaz_veri),
    .oku_adres (ps[ADR_W+1:2]),
    .oku_veri  (ram_veri)
  );

  assign adreste_gecerli = (ps[1:0] == 2'b00) && (ps[31:2] < 30'(n));
  assign buyruk          = (calisiyor && adreste_gecerli) ? ram_veri : NOP;

endmodule

// File: tb/tb_program_yukleyici.sv
// Directed self-checking bench for the program loader: normal load, gapped
// valid, out-of-range header, empty program, reset mid-load and reload.
module tb_program_yukleyici;
  import program_yukleyici_pkg::*;

  logic        saat;
  logic        reset_n;
  logic        yeniden;
  logic [31:0] ps;
  logic [31:0] buyruk;
  logic        islemci_reset;
  logic        calisiyor;
  logic        hata;

  int checks;
  int failures;

  logic [7:0] akis[$];

  program_yukleyici_if bayt_if ();

  program_yukleyici #(.DERINLIK(256)) dut (
    .saat          (saat),
    .reset_n       (reset_n),
    .bayt_if       (bayt_if),
    .yeniden       (yeniden),
    .ps            (ps),
    .buyruk        (buyruk),
    .islemci_reset (islemci_reset),
    .calisiyor     (calisiyor),
    .hata          (hata)
  );

  // Free-running clock, period 10
  initial begin
    saat = 1'b0;
    forever #5 saat = ~saat;
  end

  // Drive one cycle of stream inputs starting at a falling edge
  task automatic applyStimulus(input logic v, input logic [7:0] b);
    bayt_if.bayt_gecerli = v;
    bayt_if.bayt         = b;
    @(negedge saat);
  endtask

  // Send bytes akis[from..to] back-to-back, then drop valid
  task automatic sendStream(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      applyStimulus(1'b1, akis[i]);
    end
    bayt_if.bayt_gecerli = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic readAt(input string tag, input logic [31:0] adr, input logic [31:0] expected);
    ps = adr;
    #1;
    checkOutput(tag, buyruk, expected);
  endtask

  task automatic applyReset();
    bayt_if.bayt_gecerli = 1'b0;
    bayt_if.bayt         = 8'h00;
    yeniden              = 1'b0;
    reset_n              = 1'b0;
    @(negedge saat);
    @(negedge saat);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ps       = 32'd0;
    applyReset();

    // Reset state
    #1;
    checkOutput("rst_islemci_reset", islemci_reset, 1'b1);
    checkOutput("rst_calisiyor", calisiyor, 1'b0);
    checkOutput("rst_hata", hata, 1'b0);
    checkOutput("rst_hazir", bayt_if.bayt_hazir, 1'b1);
    checkOutput("rst_buyruk", buyruk, NOP);
    @(negedge saat);

    // Load 3 words back-to-back
    akis = '{8'h03, 8'h00,
             8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00,
             8'h33, 8'h85, 8'hB5, 8'h00};
    sendStream(0, 12);
    checkOutput("load_before_last", islemci_reset, 1'b1);
    checkOutput("load_hazir_mid", bayt_if.bayt_hazir, 1'b1);
    sendStream(13, 13);
    checkOutput("load_islemci_reset", islemci_reset, 1'b0);
    checkOutput("load_calisiyor", calisiyor, 1'b1);
    checkOutput("load_hazir_calis", bayt_if.bayt_hazir, 1'b0);
    readAt("load_ps0", 32'd0, 32'h0010_0513);
    readAt("load_ps4", 32'd4, 32'h0020_0593);
    readAt("load_ps8", 32'd8, 32'h00B5_8533);
    readAt("load_ps12", 32'd12, NOP);
    readAt("load_ps_misaligned", 32'd2, NOP);
    readAt("load_ps_high", 32'h4000_0000, NOP);
    ps = 32'd0;
    @(negedge saat);

    // Reload: yeniden with a byte presented on the same cycle
    yeniden              = 1'b1;
    bayt_if.bayt_gecerli = 1'b1;
    bayt_if.bayt         = 8'h05;
    @(negedge saat);
    yeniden              = 1'b0;
    bayt_if.bayt_gecerli = 1'b0;
    checkOutput("reload_islemci_reset", islemci_reset, 1'b1);
    checkOutput("reload_hazir", bayt_if.bayt_hazir, 1'b1);
    checkOutput("reload_calisiyor", calisiyor, 1'b0);
    readAt("reload_buyruk_nop", 32'd0, NOP);
    akis = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
    sendStream(0, 5);
    checkOutput("reload_calis", calisiyor, 1'b1);
    checkOutput("reload_hata", hata, 1'b0);
    readAt("reload_ps0", 32'd0, 32'h0000_0073);
    readAt("reload_ps4_old", 32'd4, NOP);

    // Gapped valid: invalid cycle before every byte, 28 cycles total
    applyReset();
    akis = '{8'h03, 8'h00,
             8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00,
             8'h33, 8'h85, 8'hB5, 8'h00};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 8'hFF);
      if (i == 13) begin
        checkOutput("gap_cycle27", islemci_reset, 1'b1);
      end
      applyStimulus(1'b1, akis[i]);
    end
    bayt_if.bayt_gecerli = 1'b0;
    checkOutput("gap_cycle28", islemci_reset, 1'b0);
    readAt("gap_ps0", 32'd0, 32'h0010_0513);
    readAt("gap_ps4", 32'd4, 32'h0020_0593);
    readAt("gap_ps8", 32'd8, 32'h00B5_8533);
    readAt("gap_ps12", 32'd12, NOP);

    // Reset mid-load after byte 7, then a 1-word load
    applyReset();
    sendStream(0, 6);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_islemci_reset", islemci_reset, 1'b1);
    checkOutput("midrst_hazir", bayt_if.bayt_hazir, 1'b1);
    @(negedge saat);
    reset_n = 1'b1;
    akis = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendStream(0, 5);
    checkOutput("midrst_calis", calisiyor, 1'b1);
    readAt("midrst_ps0", 32'd0, 32'hDEAD_BEEF);
    readAt("midrst_ps4", 32'd4, NOP);

    // Empty program
    applyReset();
    akis = '{8'h00, 8'h00};
    sendStream(0, 0);
    checkOutput("empty_after_byte1", islemci_reset, 1'b1);
    sendStream(1, 1);
    checkOutput("empty_islemci_reset", islemci_reset, 1'b0);
    checkOutput("empty_calisiyor", calisiyor, 1'b1);
    readAt("empty_ps0", 32'd0, NOP);

    // Header exactly DERINLIK is accepted
    applyReset();
    akis = '{8'h00, 8'h01};
    sendStream(0, 1);
    checkOutput("n256_hata", hata, 1'b0);
    checkOutput("n256_hazir", bayt_if.bayt_hazir, 1'b1);
    checkOutput("n256_islemci_reset", islemci_reset, 1'b1);

    // Header out of range is terminal until reset
    applyReset();
    akis = '{8'h01, 8'h01, 8'h00, 8'h00};
    sendStream(0, 1);
    checkOutput("n257_hata", hata, 1'b1);
    checkOutput("n257_hazir", bayt_if.bayt_hazir, 1'b0);
    checkOutput("n257_islemci_reset", islemci_reset, 1'b1);
    readAt("n257_buyruk", 32'd0, NOP);
    yeniden = 1'b1;
    sendStream(2, 3);
    yeniden = 1'b0;
    @(negedge saat);
    checkOutput("n257_stays_hata", hata, 1'b1);
    checkOutput("n257_stays_reset", islemci_reset, 1'b1);
    applyReset();
    #1;
    checkOutput("n257_cleared", hata, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
